// File: rtl/float_sub_pipe.sv
// float_sub_pipe: 3-stage pipelined IEEE-754 single-precision subtractor, diff = floatA - floatB.
// Define FLOAT_SUB_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module float_sub_pipe #(
  parameter int FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] floatA,
  input  logic [31:0] floatB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff
);

  logic        en;

  logic        signA, signB, zeroA, zeroB, infA, infB, nanA, nanB, aLarger;
  logic [7:0]  expA, expB, expX, expY, shift;
  logic [23:0] mantA, mantB, mantX, mantY;
  logic [26:0] yExt, yAligned;
  logic        sign1_d, sub1_d, spec1_d, negZero1_d;
  logic [31:0] specVal1_d;

  logic        v1_q, sign1_q, sub1_q, spec1_q, negZero1_q;
  logic [7:0]  exp1_q;
  logic [26:0] mx1_q, my1_q;
  logic [31:0] specVal1_q;

  logic [27:0] sum2_d;
  logic        v2_q, sign2_q, spec2_q, negZero2_q;
  logic [7:0]  exp2_q;
  logic [27:0] sum2_q;
  logic [31:0] specVal2_q;

  logic [4:0]        lzc;
  logic [26:0]       norm;
  logic signed [9:0] expN, expR;
  logic              roundUp;
  logic [24:0]       mantR;
  logic [22:0]       frac;
  logic [31:0]       diff_d;
  logic              unusedGrs;

  logic        v3_q;
  logic [31:0] diff_q;

  assign en        = out_ready | ~v3_q;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign diff      = diff_q;

  // Stage 1: unpack with B negated, order by magnitude, align the smaller operand.
  always_comb begin
    signA = floatA[31];
    signB = ~floatB[31];
    expA  = floatA[30:23];
    expB  = floatB[30:23];
    zeroA = (expA == 8'd0) && ((FLUSH_DENORM != 0) || (floatA[22:0] == 23'd0));
    zeroB = (expB == 8'd0) && ((FLUSH_DENORM != 0) || (floatB[22:0] == 23'd0));
    infA  = (expA == 8'hFF) && (floatA[22:0] == 23'd0);
    infB  = (expB == 8'hFF) && (floatB[22:0] == 23'd0);
    nanA  = (expA == 8'hFF) && (floatA[22:0] != 23'd0);
    nanB  = (expB == 8'hFF) && (floatB[22:0] != 23'd0);
    mantA = zeroA ? 24'd0 : {expA != 8'd0, floatA[22:0]};
    mantB = zeroB ? 24'd0 : {expB != 8'd0, floatB[22:0]};

    aLarger = {expA, mantA} >= {expB, mantB};
    expX    = aLarger ? expA : expB;
    expY    = aLarger ? expB : expA;
    mantX   = aLarger ? mantA : mantB;
    mantY   = aLarger ? mantB : mantA;
    shift   = expX - expY;
    yExt    = {mantY, 3'b000};
    if (shift >= 8'd27) begin
      yAligned = {26'd0, |mantY};
    end else begin
      yAligned = (yExt >> shift) | {26'd0, |(yExt & ((27'd1 << shift) - 27'd1))};
    end

    sign1_d    = aLarger ? signA : signB;
    sub1_d     = signA ^ signB;
    spec1_d    = nanA | nanB | infA | infB;
    negZero1_d = zeroA & zeroB & signA & signB;
    if (nanA || nanB || (infA && infB && (floatA[31] == floatB[31]))) begin
      specVal1_d = 32'h7FC00000;
    end else if (infA) begin
      specVal1_d = {floatA[31], 8'hFF, 23'd0};
    end else begin
      specVal1_d = {~floatB[31], 8'hFF, 23'd0};
    end
  end

  assign sum2_d = sub1_q ? ({1'b0, mx1_q} - {1'b0, my1_q}) : ({1'b0, mx1_q} + {1'b0, my1_q});

  // Stage 3: normalize, round, then resolve zero/overflow/underflow/special encodings.
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum2_q[i]) lzc = 5'(26 - i);
    end
    if (sum2_q[27]) begin
      norm = {sum2_q[27:2], sum2_q[1] | sum2_q[0]};
      expN = $signed({2'b00, exp2_q}) + 10'sd1;
    end else begin
      norm = sum2_q[26:0] << lzc;
      expN = $signed({2'b00, exp2_q}) - $signed({5'd0, lzc});
    end
`ifdef FLOAT_SUB_ROUND_NEAREST_EN
    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    roundUp = 1'b0;
`endif
    mantR = {1'b0, norm[26:3]} + {24'd0, roundUp};
    expR  = mantR[24] ? (expN + 10'sd1) : expN;
    frac  = mantR[24] ? mantR[23:1] : mantR[22:0];

    if (spec2_q) begin
      diff_d = specVal2_q;
    end else if (sum2_q == 28'd0) begin
      diff_d = {negZero2_q, 31'd0};
    end else if (expR >= 10'sd255) begin
      diff_d = {sign2_q, 8'hFF, 23'd0};
    end else if (expR <= 10'sd0) begin
      diff_d = {sign2_q, 31'd0};
    end else begin
      diff_d = {sign2_q, expR[7:0], frac};
    end
  end

  assign unusedGrs = ^norm[2:0];

  // Whole pipeline advances on en; bubbles travel as valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      sign1_q    <= 1'b0;
      sub1_q     <= 1'b0;
      spec1_q    <= 1'b0;
      negZero1_q <= 1'b0;
      exp1_q     <= 8'd0;
      mx1_q      <= 27'd0;
      my1_q      <= 27'd0;
      specVal1_q <= 32'd0;
      v2_q       <= 1'b0;
      sign2_q    <= 1'b0;
      spec2_q    <= 1'b0;
      negZero2_q <= 1'b0;
      exp2_q     <= 8'd0;
      sum2_q     <= 28'd0;
      specVal2_q <= 32'd0;
      v3_q       <= 1'b0;
      diff_q     <= 32'd0;
    end else if (en) begin
      v1_q       <= in_valid;
      sign1_q    <= sign1_d;
      sub1_q     <= sub1_d;
      spec1_q    <= spec1_d;
      negZero1_q <= negZero1_d;
      exp1_q     <= expX;
      mx1_q      <= {mantX, 3'b000};
      my1_q      <= yAligned;
      specVal1_q <= specVal1_d;
      v2_q       <= v1_q;
      sign2_q    <= sign1_q;
      spec2_q    <= spec1_q;
      negZero2_q <= negZero1_q;
      exp2_q     <= exp1_q;
      sum2_q     <= sum2_d;
      specVal2_q <= specVal1_q;
      v3_q       <= v2_q;
      diff_q     <= diff_d;
    end
  end

endmodule
